// File: rtl/sram_a_arbiter_if.sv
// Bundle of the two requester ports and the sram_A drive/return signals.
// Latency: none (wires only); the arbiter's timing is documented in sram_a_arbiter.
// Backpressure: a requester holds req until gnt; read returns are not backpressured.
// Modports: master = requesters + SRAM model side, slave = arbiter side.
// Stats signals exist only when SRAM_A_ARB_STATS_EN is defined.
interface sram_a_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
);
    logic              req0;
    logic              we0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] din0;
    logic              gnt0;
    logic              rvalid0;
    logic [DATA_W-1:0] rdata0;

    logic              req1;
    logic              we1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] din1;
    logic              gnt1;
    logic              rvalid1;
    logic [DATA_W-1:0] rdata1;

    logic              sram_A_we;
    logic [ADDR_W-1:0] sram_A_addr;
    logic [DATA_W-1:0] sram_A_din;
    logic [DATA_W-1:0] sram_A_dout;

`ifdef SRAM_A_ARB_STATS_EN
    logic              stat_clr;
    logic [15:0]       stat_conflicts;
    logic [15:0]       stat_gnt0;
    logic [15:0]       stat_gnt1;
`endif

    modport master (
        output req0, we0, addr0, din0,
        output req1, we1, addr1, din1,
        output sram_A_dout,
        input  gnt0, rvalid0, rdata0,
        input  gnt1, rvalid1, rdata1,
        input  sram_A_we, sram_A_addr, sram_A_din
`ifdef SRAM_A_ARB_STATS_EN
        ,
        output stat_clr,
        input  stat_conflicts, stat_gnt0, stat_gnt1
`endif
    );

    modport slave (
        input  req0, we0, addr0, din0,
        input  req1, we1, addr1, din1,
        input  sram_A_dout,
        output gnt0, rvalid0, rdata0,
        output gnt1, rvalid1, rdata1,
        output sram_A_we, sram_A_addr, sram_A_din
`ifdef SRAM_A_ARB_STATS_EN
        ,
        input  stat_clr,
        output stat_conflicts, stat_gnt0, stat_gnt1
`endif
    );
endinterface

// File: rtl/sram_a_arbiter.sv
// Two-port round-robin arbiter (bounded burst hold) for single-port sram_A.
// Latency: grant combinational in the request cycle; read data RD_LATENCY clocks after accept.
// Backpressure: requester holds req until gnt; rvalid is a one-cycle pulse, never stalled.
// Ports: rpll_clk, rst_n (synchronous, active-low), bus (sram_a_arbiter_if.slave):
//   req/we/addr/din/gnt/rvalid/rdata per requester, sram_A_we/addr/din/dout to the SRAM.
// Optional: `define SRAM_A_ARB_STATS_EN adds saturating conflict/grant counters and stat_clr.
module sram_a_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 8,
    parameter int MAX_BURST  = 4,
    parameter int RD_LATENCY = 1
) (
    input  logic                rpll_clk,
    input  logic                rst_n,
    sram_a_arbiter_if.slave     bus
);
    localparam logic [3:0] MAX_BURST_C = 4'(MAX_BURST);

    logic                  last_gnt_q, last_gnt_d;
    logic [3:0]            burst_cnt_q, burst_cnt_d;
    logic [RD_LATENCY-1:0] tag_vld_q, tag_vld_d;
    logic [RD_LATENCY-1:0] tag_id_q, tag_id_d;

    logic              gnt_any;
    logic              gnt_id;
    logic              keep_burst;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_din;
    logic              out_vld;
    logic              out_id;

    // Stay with the current owner only while it is mid-burst; a zero count
    // (fresh reset or an idle cycle) hands the conflict to the other port.
    assign keep_burst = (burst_cnt_q != 4'd0) && (burst_cnt_q < MAX_BURST_C);

    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = 1'b0;
        if (rst_n) begin
            if (bus.req0 && bus.req1) begin
                gnt_any = 1'b1;
                gnt_id  = keep_burst ? last_gnt_q : ~last_gnt_q;
            end else if (bus.req0) begin
                gnt_any = 1'b1;
                gnt_id  = 1'b0;
            end else if (bus.req1) begin
                gnt_any = 1'b1;
                gnt_id  = 1'b1;
            end
        end
    end

    assign bus.gnt0 = gnt_any & ~gnt_id;
    assign bus.gnt1 = gnt_any &  gnt_id;

    always_comb begin
        sel_we   = 1'b0;
        sel_addr = '0;
        sel_din  = '0;
        if (gnt_any) begin
            sel_we   = gnt_id ? bus.we1   : bus.we0;
            sel_addr = gnt_id ? bus.addr1 : bus.addr0;
            sel_din  = gnt_id ? bus.din1  : bus.din0;
        end
    end

    assign bus.sram_A_we   = sel_we;
    assign bus.sram_A_addr = sel_addr;
    assign bus.sram_A_din  = sel_din;

    always_comb begin
        last_gnt_d  = last_gnt_q;
        burst_cnt_d = 4'd0;
        if (gnt_any) begin
            if (gnt_id == last_gnt_q) begin
                burst_cnt_d = (burst_cnt_q == 4'hF) ? 4'hF : burst_cnt_q + 4'd1;
            end else begin
                last_gnt_d  = gnt_id;
                burst_cnt_d = 4'd1;
            end
        end
    end

    // Read tag pipeline: stage 0 captures the accepted read, the last stage
    // lines up with sram_A_dout.
    always_comb begin
        tag_vld_d    = '0;
        tag_id_d     = '0;
        tag_vld_d[0] = gnt_any & ~sel_we;
        tag_id_d[0]  = gnt_id;
        for (int i = 1; i < RD_LATENCY; i++) begin
            tag_vld_d[i] = tag_vld_q[i-1];
            tag_id_d[i]  = tag_id_q[i-1];
        end
    end

    always_ff @(posedge rpll_clk) begin
        if (!rst_n) begin
            last_gnt_q  <= 1'b1;
            burst_cnt_q <= 4'd0;
            tag_vld_q   <= '0;
            tag_id_q    <= '0;
        end else begin
            last_gnt_q  <= last_gnt_d;
            burst_cnt_q <= burst_cnt_d;
            tag_vld_q   <= tag_vld_d;
            tag_id_q    <= tag_id_d;
        end
    end

    // Gated by rst_n so a read in flight when reset asserts never surfaces.
    assign out_vld     = rst_n & tag_vld_q[RD_LATENCY-1];
    assign out_id      = tag_id_q[RD_LATENCY-1];
    assign bus.rvalid0 = out_vld & ~out_id;
    assign bus.rvalid1 = out_vld &  out_id;
    assign bus.rdata0  = bus.rvalid0 ? bus.sram_A_dout : '0;
    assign bus.rdata1  = bus.rvalid1 ? bus.sram_A_dout : '0;

`ifdef SRAM_A_ARB_STATS_EN
    logic [15:0] stat_conflicts_q, stat_conflicts_d;
    logic [15:0] stat_gnt0_q, stat_gnt0_d;
    logic [15:0] stat_gnt1_q, stat_gnt1_d;

    always_comb begin
        stat_conflicts_d = stat_conflicts_q;
        stat_gnt0_d      = stat_gnt0_q;
        stat_gnt1_d      = stat_gnt1_q;
        if (bus.stat_clr) begin
            stat_conflicts_d = '0;
            stat_gnt0_d      = '0;
            stat_gnt1_d      = '0;
        end else begin
            if (bus.req0 && bus.req1 && stat_conflicts_q != 16'hFFFF) begin
                stat_conflicts_d = stat_conflicts_q + 16'd1;
            end
            if (bus.gnt0 && stat_gnt0_q != 16'hFFFF) begin
                stat_gnt0_d = stat_gnt0_q + 16'd1;
            end
            if (bus.gnt1 && stat_gnt1_q != 16'hFFFF) begin
                stat_gnt1_d = stat_gnt1_q + 16'd1;
            end
        end
    end

    always_ff @(posedge rpll_clk) begin
        if (!rst_n) begin
            stat_conflicts_q <= '0;
            stat_gnt0_q      <= '0;
            stat_gnt1_q      <= '0;
        end else begin
            stat_conflicts_q <= stat_conflicts_d;
            stat_gnt0_q      <= stat_gnt0_d;
            stat_gnt1_q      <= stat_gnt1_d;
        end
    end

    assign bus.stat_conflicts = stat_conflicts_q;
    assign bus.stat_gnt0      = stat_gnt0_q;
    assign bus.stat_gnt1      = stat_gnt1_q;
`endif
endmodule

// File: tb/tb_sram_a_arbiter.sv
// Directed bench for sram_a_arbiter with a 1024x8 one-cycle SRAM model.
// Grants are checked in the request cycle; read responses go through a scoreboard queue.
// Preload: mem[i] = i + 8'h10, so addr 0..7 hold 8'h10..8'h17.
module tb_sram_a_arbiter;
    logic rpll_clk;
    logic rst_n;
    logic preload;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    typedef struct {
        logic       port;
        logic [7:0] data;
        int         at_cyc;
    } exp_t;

    exp_t exp_q[$];
    logic [7:0] mem [1024];

    sram_a_arbiter_if #(.ADDR_W(10), .DATA_W(8)) bus ();

    sram_a_arbiter #(
        .ADDR_W(10), .DATA_W(8), .MAX_BURST(4), .RD_LATENCY(1)
    ) dut (
        .rpll_clk (rpll_clk),
        .rst_n    (rst_n),
        .bus      (bus)
    );

    initial rpll_clk = 1'b0;
    always #5 rpll_clk = ~rpll_clk;

    always @(posedge rpll_clk) cyc <= cyc + 1;

    // SRAM model: registered read, read-before-write on the same address.
    always @(posedge rpll_clk) begin
        if (preload) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 8'(i + 16);
        end else if (bus.sram_A_we) begin
            mem[bus.sram_A_addr] <= bus.sram_A_din;
        end
        bus.sram_A_dout <= mem[bus.sram_A_addr];
    end

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, want, cyc);
        end
    endfunction

    // Monitor: pops one expectation per rvalid and checks port, data, timing.
    always @(negedge rpll_clk) begin
        if (bus.rvalid0 || bus.rvalid1) begin
            if (bus.rvalid0 && bus.rvalid1) begin
                chk("rvalid_both", 32'd1, 32'd0);
            end else if (exp_q.size() == 0) begin
                chk("rvalid_unexpected", 32'(bus.rvalid1), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rsp_port", 32'(bus.rvalid1), 32'(e.port));
                chk("rsp_data", 32'(e.port ? bus.rdata1 : bus.rdata0), 32'(e.data));
                chk("rsp_other_zero", 32'(e.port ? bus.rdata0 : bus.rdata1), 32'd0);
                chk("rsp_cycle", 32'(cyc), 32'(e.at_cyc));
            end
        end
    end

    task automatic drive(input logic r0, w0, input logic [9:0] a0, input logic [7:0] d0,
                         input logic r1, w1, input logic [9:0] a1, input logic [7:0] d1);
        bus.req0 = r0; bus.we0 = w0; bus.addr0 = a0; bus.din0 = d0;
        bus.req1 = r1; bus.we1 = w1; bus.addr1 = a1; bus.din1 = d1;
    endtask

    // Drive one cycle, check grants mid-cycle, queue expected read returns.
    task automatic step(input logic r0, w0, input logic [9:0] a0, input logic [7:0] d0,
                        input logic r1, w1, input logic [9:0] a1, input logic [7:0] d1,
                        input logic e0, e1, input logic [7:0] x0, x1, input string nm);
        drive(r0, w0, a0, d0, r1, w1, a1, d1);
        @(negedge rpll_clk);
        chk({nm, ".gnt0"}, 32'(bus.gnt0), 32'(e0));
        chk({nm, ".gnt1"}, 32'(bus.gnt1), 32'(e1));
        if (e0 && !w0) exp_q.push_back('{1'b0, x0, cyc + 1});
        if (e1 && !w1) exp_q.push_back('{1'b1, x1, cyc + 1});
    endtask

    task automatic adv();
        @(posedge rpll_clk);
        #1;
    endtask

    task automatic idle(input string nm);
        step(0, 0, 10'd0, 8'h00, 0, 0, 10'd0, 8'h00, 0, 0, 8'h00, 8'h00, nm);
        chk({nm, ".we"}, 32'(bus.sram_A_we), 32'd0);
        chk({nm, ".addr"}, 32'(bus.sram_A_addr), 32'd0);
        adv();
    endtask

    task automatic reset_outputs_zero(input string nm);
        chk({nm, ".we"}, 32'(bus.sram_A_we), 32'd0);
        chk({nm, ".addr"}, 32'(bus.sram_A_addr), 32'd0);
        chk({nm, ".din"}, 32'(bus.sram_A_din), 32'd0);
        chk({nm, ".rvalid0"}, 32'(bus.rvalid0), 32'd0);
        chk({nm, ".rvalid1"}, 32'(bus.rvalid1), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish (cycle %0d)", cyc);
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "timeout");
    end

    initial begin
        rst_n   = 1'b0;
        preload = 1'b1;
`ifdef SRAM_A_ARB_STATS_EN
        bus.stat_clr = 1'b0;
`endif
        drive(0, 0, 10'd0, 8'h00, 0, 0, 10'd0, 8'h00);
        adv();
        preload = 1'b0;

        // Requests during reset: nothing granted, SRAM bus quiet.
        step(1, 1, 10'd5, 8'h77, 1, 1, 10'd6, 8'h66, 0, 0, 8'h00, 8'h00, "rst0");
        reset_outputs_zero("rst0");
        adv();
        rst_n = 1'b1;

        // Continuous conflict from reset: 0,0,0,0,1,1,1,1,0,0,0,0.
        for (int i = 0; i < 12; i++) begin
            logic g0;
            g0 = ((i / 4) % 2) == 0;
            step(1, 0, 10'd20, 8'h00, 1, 0, 10'd30, 8'h00, g0, !g0, 8'h24, 8'h2E, "rr");
            adv();
        end
        idle("idle1");

        // Port 1 streams addr 0..7, one response per cycle in order.
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 10'd0, 8'h00, 1, 0, 10'(i), 8'h00, 0, 1, 8'h00, 8'(8'h10 + i), "stream");
            chk("stream.addr", 32'(bus.sram_A_addr), 32'(i));
            adv();
        end
        idle("idle2");

        // Write 8'hAA to addr 0, read it back through port 1 next cycle.
        step(1, 1, 10'd0, 8'hAA, 0, 0, 10'd0, 8'h00, 1, 0, 8'h00, 8'h00, "wr");
        chk("wr.we", 32'(bus.sram_A_we), 32'd1);
        chk("wr.din", 32'(bus.sram_A_din), 32'hAA);
        chk("wr.addr", 32'(bus.sram_A_addr), 32'd0);
        adv();
        step(0, 0, 10'd0, 8'h00, 1, 0, 10'd0, 8'h00, 0, 1, 8'h00, 8'hAA, "rdback");
        chk("rdback.we", 32'(bus.sram_A_we), 32'd0);
        adv();
        idle("idle3");

        // req0 joins port 1's burst, idle cycle, then port 0 wins the conflict.
        step(0, 0, 10'd2, 8'h00, 1, 0, 10'd1, 8'h00, 0, 1, 8'h00, 8'h11, "late0a");
        adv();
        step(1, 0, 10'd2, 8'h00, 1, 0, 10'd1, 8'h00, 0, 1, 8'h00, 8'h11, "late0b");
        adv();
        idle("idle4");
        step(1, 0, 10'd2, 8'h00, 1, 0, 10'd1, 8'h00, 1, 0, 8'h12, 8'h00, "after_idle");
        adv();
        idle("idle5");

        // Port 1 read accepted, reset next cycle: no response for it.
        step(0, 0, 10'd0, 8'h00, 1, 0, 10'd3, 8'h00, 0, 1, 8'h00, 8'h00, "flush_rd");
        exp_q.pop_back();
        adv();
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step(1, 1, 10'd5, 8'hFF, 1, 1, 10'd6, 8'hFF, 0, 0, 8'h00, 8'h00, "rst1");
            reset_outputs_zero("rst1");
            adv();
        end
        rst_n = 1'b1;
        step(1, 0, 10'd4, 8'h00, 1, 0, 10'd5, 8'h00, 1, 0, 8'h14, 8'h15, "post_rst");
        adv();
        idle("idle6");

`ifdef SRAM_A_ARB_STATS_EN
        rst_n = 1'b0;
        idle("rst2");
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            logic g0;
            g0 = ((i / 4) % 2) == 0;
            step(1, 1, 10'd900, 8'h01, 1, 1, 10'd901, 8'h02, g0, !g0, 8'h00, 8'h00, "stat_cf");
            adv();
        end
        bus.stat_clr = 1'b1;
        step(0, 0, 10'd0, 8'h00, 0, 0, 10'd0, 8'h00, 0, 0, 8'h00, 8'h00, "stat_clr");
        chk("stat_conflicts", 32'(bus.stat_conflicts), 32'd10);
        chk("stat_gnt0", 32'(bus.stat_gnt0), 32'd6);
        chk("stat_gnt1", 32'(bus.stat_gnt1), 32'd4);
        adv();
        bus.stat_clr = 1'b0;
        step(0, 0, 10'd0, 8'h00, 0, 0, 10'd0, 8'h00, 0, 0, 8'h00, 8'h00, "stat_after");
        chk("stat_conflicts_clr", 32'(bus.stat_conflicts), 32'd0);
        chk("stat_gnt0_clr", 32'(bus.stat_gnt0), 32'd0);
        chk("stat_gnt1_clr", 32'(bus.stat_gnt1), 32'd0);
        adv();
`endif

        for (int k = 0; k < 10 && exp_q.size() != 0; k++) adv();
        chk("drain", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
